// File: rtl/max6675_pkg.sv
// max6675_pkg: shared scan FSM states, register word offsets, DATA field positions and helpers
// No ports; imported by max6675_scan.
package max6675_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_NEXT} state_t;
  localparam logic [3:0] A_CTRL = 4'h0, A_STATUS = 4'h1, A_PERIOD = 4'h2, A_ENMASK = 4'h3, A_DATA = 4'h8;
  localparam logic [31:0] PERIOD_RST = 32'd12_000_000;
  localparam int D_OPEN = 12, D_ERR = 13, D_VALID = 14;
  function automatic logic [14:0] decode(input logic [15:0] f);
    decode = '0;
    decode[11:0] = f[14:3];
    decode[D_OPEN] = f[2];
    decode[D_ERR] = f[15] | f[1];
    decode[D_VALID] = 1'b1;
  endfunction
  // Lowest enabled channel at index >= from; 8 means none.
  function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] from);
    find_ch = 4'd8;
    for (int i = 7; i >= 0; i--) if (m[i] && i >= int'(from)) find_ch = 4'(i);
  endfunction
endpackage

// File: rtl/max6675_scan_if.sv
// max6675_scan_if: PicoSoC iomem bus bundle
// master drives valid/addr/wdata/wstrb; slave returns ready/rdata.
interface max6675_scan_if;
  logic iomem_valid, iomem_ready;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic [3:0] iomem_wstrb;
  modport master (output iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb, input iomem_ready, iomem_rdata);
  modport slave (input iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb, output iomem_ready, iomem_rdata);
endinterface

// File: rtl/max6675_shifter.sv
// max6675_shifter: SCK divider and 16-bit MISO shift with start/done handshake
// i_start starts a frame when idle, i_so is MISO; o_sck mode-0 clock, o_done one-cycle pulse, o_frame MSB-first data.
module max6675_shifter #(
  parameter int DIV = 25
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_so,
  output logic        o_sck,
  output logic        o_done,
  output logic [15:0] o_frame
);
  localparam int CW = $clog2(DIV + 1);
  logic r_act;
  logic [CW-1:0] r_cnt;
  logic [4:0] r_bits;
  logic w_tog;
  assign w_tog = r_act && r_cnt == CW'(DIV - 1);
  // The toggle after the 16th high phase lands sck low and ends the frame.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_act <= 1'b0;
      r_cnt <= '0;
      r_bits <= '0;
      o_sck <= 1'b0;
      o_done <= 1'b0;
      o_frame <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_start && !r_act) begin
        r_act <= 1'b1;
        r_cnt <= '0;
        r_bits <= '0;
        o_sck <= 1'b0;
      end else if (r_act) begin
        r_cnt <= w_tog ? '0 : r_cnt + 1'b1;
        if (w_tog) begin
          o_sck <= ~o_sck;
          if (!o_sck) begin
            o_frame <= {o_frame[14:0], i_so};
            r_bits <= r_bits + 5'd1;
          end else if (r_bits == 5'd16) begin
            r_act <= 1'b0;
            o_done <= 1'b1;
          end
        end
      end
    end
endmodule

// File: rtl/max6675_scan.sv
// max6675_scan: multi-channel MAX6675 thermocouple scanner on the PicoSoC iomem bus
// bus: iomem slave (CTRL/STATUS/PERIOD/ENMASK/DATA_i); cs_n per-channel select; sck/so shared SPI.
// MAX6675_SCAN_IRQ_EN adds the irq port and CTRL bit2 IRQEN.
module max6675_scan
  import max6675_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int SCK_HZ = 1_000_000,
  parameter int NCH = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic           clk,
  input  logic           resetn,
  max6675_scan_if.slave  bus,
  output logic [NCH-1:0] cs_n,
  output logic           sck,
  input  logic           so
`ifdef MAX6675_SCAN_IRQ_EN
  , output logic         irq
`endif
);
  localparam int DIV = CLK_HZ / (2 * SCK_HZ) < 1 ? 1 : CLK_HZ / (2 * SCK_HZ);
  localparam int CW = $clog2(DIV + 1);
`ifdef MAX6675_SCAN_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  state_t r_state, w_nxt;
  logic [2:0] r_ch;
  logic [3:0] w_ch, w_a;
  logic [CW-1:0] r_cnt;
  logic r_ready, r_auto, r_irqen;
  logic [31:0] r_rdata, r_period, r_pcnt, w_per, w_rd, w_wm, w_wd;
  logic [NCH-1:0] r_en, r_fresh, w_set;
  logic [14:0] r_data [NCH];
  logic w_acc, w_wr, w_start, w_tick, w_go, w_cdone, w_sh_start, w_sh_done;
  logic [15:0] w_frame;
  max6675_shifter #(.DIV(DIV)) u_sh (
    .clk(clk), .resetn(resetn), .i_start(w_sh_start), .i_so(so),
    .o_sck(sck), .o_done(w_sh_done), .o_frame(w_frame)
  );
  // Gating on r_ready makes a held valid produce one access per two cycles.
  assign w_acc = bus.iomem_valid && !r_ready && bus.iomem_addr[31:6] == BASE_ADDR[31:6];
  assign w_wr = w_acc && |bus.iomem_wstrb;
  assign w_a = bus.iomem_addr[5:2];
  assign w_wm = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}}, {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
  assign w_wd = bus.iomem_wdata & w_wm;
  assign w_start = w_wr && w_a == A_CTRL && w_wd[0];
  assign w_per = r_period == '0 ? 32'd1 : r_period;
  assign w_tick = r_auto && r_pcnt >= w_per - 32'd1;
  assign w_go = (w_start || w_tick) && |r_en;
  assign w_cdone = r_cnt == CW'(DIV - 1);
  assign w_set = r_state == S_SHIFT && w_sh_done ? NCH'(1) << r_ch : '0;
  assign cs_n = r_state == S_SETUP || r_state == S_SHIFT ? ~(NCH'(1) << r_ch) : '1;
  assign bus.iomem_ready = r_ready;
  assign bus.iomem_rdata = r_rdata;
`ifdef MAX6675_SCAN_IRQ_EN
  assign irq = r_irqen && |r_fresh;
`endif
  always_comb begin
    w_nxt = r_state;
    w_ch = find_ch(8'(r_en), 4'd0);
    w_sh_start = 1'b0;
    case (r_state)
      S_IDLE: if (w_go) w_nxt = S_SETUP;
      S_SETUP: if (w_cdone) begin
        w_nxt = S_SHIFT;
        w_sh_start = 1'b1;
      end
      S_SHIFT: if (w_sh_done) w_nxt = S_HOLD;
      S_HOLD: if (w_cdone) w_nxt = S_NEXT;
      S_NEXT: begin
        w_ch = find_ch(8'(r_en), 4'(r_ch) + 4'd1);
        w_nxt = w_ch[3] ? S_IDLE : S_SETUP;
      end
      default: w_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    w_rd = '0;
    case (w_a)
      A_CTRL: w_rd[2:1] = {r_irqen, r_auto};
      A_STATUS: begin
        w_rd[8 +: NCH] = r_fresh;
        w_rd[0] = r_state != S_IDLE;
      end
      A_PERIOD: w_rd = r_period;
      A_ENMASK: w_rd[NCH-1:0] = r_en;
      default: for (int i = 0; i < NCH; i++) if (w_a == A_DATA + 4'(i)) w_rd[14:0] = r_data[i];
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ch <= '0;
      r_cnt <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_auto <= 1'b0;
      r_irqen <= 1'b0;
      r_period <= PERIOD_RST;
      r_pcnt <= '0;
      r_en <= '1;
      r_fresh <= '0;
      for (int i = 0; i < NCH; i++) r_data[i] <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt == S_SETUP && r_state != S_SETUP) r_ch <= w_ch[2:0];
      r_cnt <= r_state != w_nxt ? '0 : r_cnt + 1'b1;
      r_ready <= w_acc;
      r_rdata <= w_acc && !w_wr ? w_rd : '0;
      r_pcnt <= r_auto && !w_tick ? r_pcnt + 32'd1 : '0;
      r_fresh <= r_fresh & ~(w_wr && w_a == A_STATUS ? w_wd[8 +: NCH] : '0) | w_set;
      if (w_wr && w_a == A_CTRL && bus.iomem_wstrb[0]) begin
        r_auto <= bus.iomem_wdata[1];
        r_irqen <= IRQ && bus.iomem_wdata[2];
      end
      if (w_wr && w_a == A_PERIOD) r_period <= r_period & ~w_wm | w_wd;
      if (w_wr && w_a == A_ENMASK && bus.iomem_wstrb[0]) r_en <= bus.iomem_wdata[NCH-1:0];
      for (int i = 0; i < NCH; i++) if (w_set[i]) r_data[i] <= decode(w_frame);
    end
endmodule
